sel_led_indicator: RTL and testbench

//  Parametrised successor to the 2-bit selector/LED block: debounces a front-panel select code.

---
 rtl/sel_led_indicator.sv | 166 ++++++++++++++++
 tb/tb_sel_led_indicator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_led_indicator.sv
// sel_led_indicator
//   Debounces a raw front-panel select code and commits it once it has been
//   stable long enough. The committed code drives a registered table value
//   and an N-LED status pattern. Codes that fit one-hot on the LEDs light a
//   single steady LED. Larger codes show their low bits in binary, gated by a
//   free-running blink phase.
// Ports
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   sel     in   SEL_W  raw select code, asynchronous to clk
//   out     out  OUT_W  registered VALUE_TABLE entry of the committed code
//   led     out  N_LED  registered status pattern, led[0] = LED0
//   changed out  1      one-cycle pulse when out/led take a newly committed code
module sel_led_indicator #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned OUT_W      = 11,
  parameter int unsigned N_LED      = 3,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned BLINK_DIV  = 8,
  parameter logic [(2**SEL_W)*OUT_W-1:0] VALUE_TABLE = {11'd20, 11'd15, 11'd10, 11'd5}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [N_LED-1:0] led,
  output logic             changed
);

  localparam int unsigned CNT_W   = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned BCNT_W  = $clog2(BLINK_DIV) + 1;
  localparam int unsigned EXT_W   = SEL_W + N_LED;
  localparam int unsigned ENTRIES = 2 ** SEL_W;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_DIV - 1);

  typedef enum logic {StStable, StSettle} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sync_q;
  logic [SEL_W-1:0]   sel_s_q;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit;
  logic               commit_q;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [N_LED-1:0]   led_q, led_d;
  logic               changed_q, changed_d;
  logic [BCNT_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [EXT_W-1:0]   code_ext;
  logic [OUT_W-1:0]   table_arr [ENTRIES];

  for (genvar k = 0; k < ENTRIES; k++) begin : g_table
    assign table_arr[k] = VALUE_TABLE[k*OUT_W +: OUT_W];
  end

  // State register: synchroniser, debounce FSM, output stage and blink timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      sel_s_q     <= '0;
      sel_q       <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      state_q     <= StStable;
      commit_q    <= 1'b0;
      out_q       <= VALUE_TABLE[OUT_W-1:0];
      led_q       <= N_LED'(1);
      changed_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
    end else begin
      sync_q      <= sel;
      sel_s_q     <= sync_q;
      sel_q       <= sel_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      commit_q    <= commit;
      out_q       <= out_d;
      led_q       <= led_d;
      changed_q   <= changed_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStable: begin
        if (sel_s_q != sel_q) state_d = StSettle;
      end
      StSettle: begin
        if (sel_s_q == sel_q) begin
          state_d = StStable;
        end else if (sel_s_q != cand_q) begin
          state_d = StSettle;
        end else if (cnt_q == CNT_LAST) begin
          state_d = StStable;
        end
      end
    endcase
  end

  // FSM datapath outputs: candidate tracking, settle counter and commit.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    commit = 1'b0;
    unique case (state_q)
      StStable: begin
        if (sel_s_q != sel_q) begin
          cand_d = sel_s_q;
          cnt_d  = '0;
        end
      end
      StSettle: begin
        if (sel_s_q == sel_q) begin
          // Input went back to the committed code: glitch, nothing to do.
        end else if (sel_s_q != cand_q) begin
          cand_d = sel_s_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          sel_d  = cand_q;
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Output stage: one register behind sel_q, so changed is the delayed commit.
  always_comb begin
    code_ext  = EXT_W'(sel_q);
    out_d     = table_arr[sel_q];
    changed_d = commit_q;
    if (code_ext < EXT_W'(N_LED)) begin
      led_d = N_LED'(1) << sel_q;
    end else begin
      led_d = code_ext[N_LED-1:0] & {N_LED{blink_ph_q}};
    end
  end

  // Free-running blink timer; the phase flips on every wrap.
  always_comb begin
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BCNT_W'(1);
      blink_ph_d  = blink_ph_q;
    end
  end

  assign out     = out_q;
  assign led     = led_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_sel_led_indicator.sv
// Testbench for sel_led_indicator: a default-parameter instance checked every
// cycle against a run-length debounce model, plus a SEL_W=3 / DEB_CYCLES=1
// instance checked for latency and full table lookup.
module tb_sel_led_indicator;

  localparam int DEB_A = 4;
  localparam int DIV_A = 8;
  localparam logic [63:0] TABLE_B = {8'd98, 8'd85, 8'd72, 8'd59, 8'd46, 8'd33, 8'd20, 8'd7};

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_a;
  logic [10:0] out_a;
  logic [2:0]  led_a;
  logic        changed_a;
  logic [2:0]  sel_b;
  logic [7:0]  out_b;
  logic [3:0]  led_b;
  logic        changed_b;

  int checks = 0;
  int errors = 0;

  // Reference model state for instance A.
  int   committed;
  int   run_val;
  int   run_len;
  int   edge_n;
  bit   ph;
  bit   commit_flag;
  int   sh[$];
  logic [10:0] exp_out;
  logic [2:0]  exp_led;
  logic        exp_changed;

  always #5 clk = ~clk;

  sel_led_indicator u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel_a),
    .out     (out_a),
    .led     (led_a),
    .changed (changed_a)
  );

  sel_led_indicator #(
    .SEL_W       (3),
    .OUT_W       (8),
    .N_LED       (4),
    .DEB_CYCLES  (1),
    .BLINK_DIV   (8),
    .VALUE_TABLE (TABLE_B)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel_b),
    .out     (out_b),
    .led     (led_b),
    .changed (changed_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Table of instance A is 5, 10, 15, 20.
  function automatic logic [10:0] ref_out_a(input int k);
    return 11'(5 * (k + 1));
  endfunction

  function automatic logic [2:0] ref_led_a(input int k, input bit phase);
    if (k < 3) return 3'b001 << k;
    return phase ? k[2:0] : 3'b000;
  endfunction

  task automatic model_init();
    committed   = 0;
    run_val     = 0;
    run_len     = 1;
    edge_n      = 0;
    ph          = 1'b1;
    commit_flag = 1'b0;
    sh          = {};
    sh.push_back(0);
    sh.push_back(0);
  endtask

  // One clock edge of instance A with sel held at s, then check all outputs.
  // A code commits once the synchronised input (sel two edges earlier) has
  // shown the same non-committed value on DEB_A+1 consecutive edges.
  task automatic step(input logic [1:0] s);
    int s_n;
    sel_a = s;
    @(posedge clk);
    sh.push_back(int'(s));
    s_n = sh.pop_front();
    exp_out     = ref_out_a(committed);
    exp_led     = ref_led_a(committed, ph);
    exp_changed = commit_flag;
    if (s_n == run_val) begin
      run_len++;
    end else begin
      run_val = s_n;
      run_len = 1;
    end
    commit_flag = (run_len >= DEB_A + 1) && (run_val != committed);
    if (commit_flag) committed = run_val;
    edge_n++;
    ph = ((edge_n / DIV_A) % 2) == 0;
    #1;
    chk("out_a", 32'(out_a), 32'(exp_out));
    chk("led_a", 32'(led_a), 32'(exp_led));
    chk("changed_a", 32'(changed_a), 32'(exp_changed));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst   = 1'b1;
    sel_a = '0;
    sel_b = '0;
    #1;
    chk("rst_out", 32'(out_a), 32'd5);
    chk("rst_led", 32'(led_a), 32'b001);
    chk("rst_changed", 32'(changed_a), 32'd0);
    chk("rst_out_b", 32'(out_b), 32'd7);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_init();
  endtask

  task automatic hold(input logic [1:0] s, input int n, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= n; i++) begin
      step(s);
      if (changed_a === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    int pulses;
    int first;
    int lat;
    bit seen_on;
    bit seen_off;
    logic [2:0] kb;

    rst   = 1'b1;
    sel_a = '0;
    sel_b = '0;
    model_init();
    apply_reset();

    // 0 -> 1 held: commit visible 8 edges after the change.
    hold(2'd1, 12, pulses, first);
    chk("t2_latency", 32'(first), 32'd8);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_out", 32'(out_a), 32'd10);
    chk("t2_led", 32'(led_a), 32'b010);

    hold(2'd0, 12, pulses, first);
    chk("back0_out", 32'(out_a), 32'd5);

    // Short excursion to 2 is rejected.
    hold(2'd2, 3, pulses, first);
    chk("t3_pulses_a", 32'(pulses), 32'd0);
    hold(2'd0, 12, pulses, first);
    chk("t3_pulses_b", 32'(pulses), 32'd0);
    chk("t3_out", 32'(out_a), 32'd5);

    // 1 briefly, then 2 held: the settle count restarts and 2 commits once.
    hold(2'd1, 2, pulses, first);
    chk("t4_pulses_a", 32'(pulses), 32'd0);
    hold(2'd2, 12, pulses, first);
    chk("t4_pulses_b", 32'(pulses), 32'd1);
    chk("t4_out", 32'(out_a), 32'd15);
    chk("t4_led", 32'(led_a), 32'b100);

    // Code 3 is beyond one-hot range and blinks.
    seen_on  = 1'b0;
    seen_off = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(2'd3);
      if (i >= 12 && led_a === 3'b011) seen_on = 1'b1;
      if (i >= 12 && led_a === 3'b000) seen_off = 1'b1;
    end
    chk("t5_out", 32'(out_a), 32'd20);
    chk("t5_seen_on", 32'(seen_on), 32'd1);
    chk("t5_seen_off", 32'(seen_off), 32'd1);

    // Reset in the middle of a settle toward code 1.
    step(2'd1);
    step(2'd1);
    step(2'd1);
    step(2'd1);
    apply_reset();
    hold(2'd0, 6, pulses, first);
    chk("t1_no_pulse", 32'(pulses), 32'd0);

    // Random hold lengths around the debounce threshold.
    for (int seg = 0; seg < 60; seg++) begin
      logic [1:0] v;
      int len;
      v   = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) step(v);
    end

    // Second instance: DEB_CYCLES=1, every code, latency 5 edges.
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      int k;
      k  = (n + 1) % 8;
      kb = 3'(k);
      @(negedge clk);
      sel_b = kb;
      lat   = 99;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (changed_b === 1'b1) begin
          lat = i;
          break;
        end
      end
      chk("t6_latency", 32'(lat), 32'd5);
      chk("t6_out", 32'(out_b), 32'(7 + 13 * k));
      if (k < 4) chk("t6_led", 32'(led_b), 32'(1 << k));
      @(posedge clk);
      #1;
      chk("t6_pulse_end", 32'(changed_b), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
